ez8_loader: RTL and testbench

- Boot and program-load controller for the ez8 core.
- Accepts a byte stream from a host over a valid/ready handshake and packs it into 16-bit instructions, high byte first.
- Drives the CPU's instruction-memory write port with sequential writes starting at address 0.
- Holds the CPU in reset while loading; releases it after the final word is written.

---
 rtl/ez8_loader.sv | 101 ++++++++++
 tb/tb_ez8_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ez8_loader.sv
// ez8_loader: packs a host byte stream into 16-bit words, writes them to instruction memory from address 0, holds the CPU in reset until the load completes
module ez8_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_last,
  input  logic                  load_abort,
  input  logic                  host_valid,
  input  logic [7:0]            host_data,
  output logic                  host_ready,
  output logic [ADDR_WIDTH-1:0] instr_writeaddr,
  output logic [15:0]           instr_writedata,
  output logic                  instr_write_en,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            checksum
);
  typedef enum logic [2:0] {IDLE, HI, LO, WR, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d, cnt_q, cnt_d, addr_q, addr_d;
  logic [7:0] hi_q, hi_d, sum_q, sum_d;
  logic [15:0] data_q, data_d;
  logic cpu_rst_q, cpu_rst_d;
  logic hs;
  assign host_ready = state_q == HI || state_q == LO;
  assign busy = state_q == HI || state_q == LO || state_q == WR;
  assign done = state_q == DONE;
  assign instr_write_en = state_q == WR && !load_abort;
  assign instr_writeaddr = addr_q;
  assign instr_writedata = data_q;
  assign cpu_reset = cpu_rst_q;
  assign checksum = sum_q;
  assign hs = host_valid && host_ready;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    hi_d = hi_q;
    sum_d = sum_q;
    data_d = data_q;
    cpu_rst_d = cpu_rst_q;
    case (state_q)
      IDLE: if (load_start) begin
        last_d = load_last;
        cnt_d = '0;
        sum_d = '0;
        cpu_rst_d = 1'b1;
        state_d = HI;
      end
      HI: if (load_abort) state_d = IDLE;
        else if (hs) begin
          hi_d = host_data;
          sum_d = sum_q + host_data;
          state_d = LO;
        end
      LO: if (load_abort) state_d = IDLE;
        else if (hs) begin
          data_d = {hi_q, host_data};
          addr_d = cnt_q;
          sum_d = sum_q + host_data;
          state_d = WR;
        end
      WR: if (load_abort) state_d = IDLE;
        else if (cnt_q == last_q) state_d = DONE;
        else begin
          cnt_d = cnt_q + 1'b1;
          state_d = HI;
        end
      DONE: begin
        cpu_rst_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      hi_q <= '0;
      sum_q <= '0;
      data_q <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      hi_q <= hi_d;
      sum_q <= sum_d;
      data_q <= data_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end
endmodule

// File: tb/tb_ez8_loader.sv
// tb_ez8_loader: directed scoreboard bench for ez8_loader
module tb_ez8_loader;
  logic clk = 1'b0;
  logic reset, load_start, load_abort, host_valid;
  logic [11:0] load_last;
  logic [7:0] host_data;
  logic host_ready, instr_write_en, cpu_reset, busy, done;
  logic [11:0] instr_writeaddr;
  logic [15:0] instr_writedata;
  logic [7:0] checksum;
  ez8_loader #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_last(load_last),
    .load_abort(load_abort), .host_valid(host_valid), .host_data(host_data),
    .host_ready(host_ready), .instr_writeaddr(instr_writeaddr),
    .instr_writedata(instr_writedata), .instr_write_en(instr_write_en),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .checksum(checksum)
  );
  always #5 clk = ~clk;
  int n_pass = 0, n_tot = 0, n_writes = 0, n_done = 0, cyc = 0, last_cyc = -1, exp_gap = 0;
  int w0, d0;
  logic [11:0] last_addr = '0, addr_m = '0;
  logic [7:0] exp_sum = '0;
  logic [27:0] exp_q[$];
  logic [7:0] src[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (instr_write_en) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("write", {instr_writeaddr, instr_writedata}, exp_q.pop_front());
      chk("ready_in_wr", host_ready, 0);
      if (exp_gap != 0 && last_cyc >= 0) chk("write_spacing", cyc - last_cyc, exp_gap);
      last_cyc = cyc;
      last_addr = instr_writeaddr;
      n_writes++;
    end
    if (done) n_done++;
  end
  task automatic send_byte(input logic [7:0] b, input bit gap);
    logic r;
    int k;
    if (gap) begin
      host_valid = 1'b0;
      @(posedge clk); #1;
    end
    host_valid = 1'b1;
    host_data = b;
    k = 0;
    do begin
      @(negedge clk);
      r = host_ready;
      @(posedge clk); #1;
      k++;
    end while (!r && k < 20);
    if (!r) chk("hs_timeout", r, 1);
    host_valid = 1'b0;
    host_data = 8'hxx;
    exp_sum += b;
  endtask
  task automatic feed(input bit gap);
    logic [7:0] b0, b1;
    while (src.size() >= 2) begin
      b0 = src.pop_front();
      b1 = src.pop_front();
      exp_q.push_back({addr_m, b0, b1});
      addr_m++;
      send_byte(b0, gap);
      send_byte(b1, gap);
    end
  endtask
  task automatic start_load(input logic [11:0] last);
    load_start = 1'b1;
    load_last = last;
    @(posedge clk); #1;
    load_start = 1'b0;
    addr_m = '0;
    exp_sum = '0;
    last_cyc = -1;
    chk("start_busy", busy, 1);
    chk("start_ready", host_ready, 1);
    chk("start_sum_clear", checksum, 0);
    chk("start_cpu_reset", cpu_reset, 1);
  endtask
  initial begin
    reset = 1'b1; load_start = 1'b1; load_last = 12'h3; load_abort = 1'b0;
    host_valid = 1'b0; host_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; load_start = 1'b0;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_ready", host_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", instr_write_en, 0);
    chk("rst_sum", checksum, 0);
    chk("rst_addr_data", {instr_writeaddr, instr_writedata}, 0);
    @(posedge clk); #1;
    chk("rst_start_ignored", busy, 0);
    // two words, host always valid, load_start held through WR and DONE
    w0 = n_writes; d0 = n_done; exp_gap = 3;
    start_load(12'h1);
    src = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    feed(0);
    load_start = 1'b1; load_last = 12'h5;
    @(posedge clk); #1;
    chk("l1_done", done, 1);
    chk("l1_done_busy", busy, 0);
    chk("l1_done_cpu_reset", cpu_reset, 1);
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("l1_done_pulse", done, 0);
    chk("l1_cpu_release", cpu_reset, 0);
    chk("l1_sum", checksum, exp_sum);
    chk("l1_writes", n_writes - w0, 2);
    chk("l1_dones", n_done - d0, 1);
    @(posedge clk); #1;
    chk("l1_start_in_done_ignored", busy, 0);
    chk("l1_idle_ready", host_ready, 0);
    exp_gap = 0;
    // toggling host_valid, load_start with different load_last mid-load
    w0 = n_writes; d0 = n_done;
    start_load(12'h1);
    src = '{8'h12, 8'h34};
    feed(1);
    @(posedge clk); #1;
    load_start = 1'b1; load_last = 12'h0;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("l2_mid_start_busy", busy, 1);
    src = '{8'hAB, 8'hCD};
    feed(1);
    @(posedge clk); #1;
    chk("l2_done", done, 1);
    @(posedge clk); #1;
    chk("l2_cpu_release", cpu_reset, 0);
    chk("l2_sum", checksum, exp_sum);
    chk("l2_writes", n_writes - w0, 2);
    chk("l2_dones", n_done - d0, 1);
    // abort in LO after first byte of word 1
    w0 = n_writes; d0 = n_done;
    start_load(12'h2);
    src = '{8'h11, 8'h22};
    feed(0);
    send_byte(8'h33, 0);
    load_abort = 1'b1;
    @(posedge clk); #1;
    load_abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_ready", host_ready, 0);
    chk("ab_cpu_reset", cpu_reset, 1);
    chk("ab_sum", checksum, exp_sum);
    chk("ab_writes", n_writes - w0, 1);
    @(posedge clk); #1;
    chk("ab_no_done", n_done - d0, 0);
    // abort coinciding with WR suppresses the write
    w0 = n_writes;
    start_load(12'h2);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    load_abort = 1'b1;
    @(posedge clk); #1;
    load_abort = 1'b0;
    chk("abwr_writes", n_writes - w0, 0);
    chk("abwr_busy", busy, 0);
    chk("abwr_cpu_reset", cpu_reset, 1);
    // full memory load
    w0 = n_writes; d0 = n_done; exp_gap = 3;
    start_load(12'hFFF);
    for (int i = 0; i < 8192; i++) src.push_back(8'(i));
    feed(0);
    @(posedge clk); #1;
    chk("full_done", done, 1);
    @(posedge clk); #1;
    chk("full_writes", n_writes - w0, 4096);
    chk("full_last_addr", last_addr, 12'hFFF);
    chk("full_dones", n_done - d0, 1);
    chk("full_sum", checksum, exp_sum);
    chk("full_sb_empty", exp_q.size(), 0);
    chk("full_cpu_release", cpu_reset, 0);
    exp_gap = 0;
    repeat (3) @(posedge clk);
    #1 chk("final_dones", n_done - d0, 1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
